// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC select, load-use stall, redirect flush, interrupt entry.
// Latency: one cycle from fetch address to IF/ID outputs. imem_addr and id_ex_bubble are combinational.
// Backpressure: a load-use hazard holds the PC and IF/ID and bubbles ID/EX. A taken branch overrides the hold.
// Optional: define STALL_COUNT_EN to build the saturating load-use stall counter on stall_cnt.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC  = 32'h8000_0004,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        irq,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        id_ex_bubble,
    output logic [31:0] epc,
    output logic        irq_taken,
    output logic [31:0] stall_cnt
);

    // Interrupt sequencing states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_ENTER = 2'd2;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        valid_q, valid_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  state_q, state_d;

    logic [31:0] pc_plus4;
    logic        hazard;
    logic        irq_enter;

    assign pc_plus4     = pc_q + 32'd4;
    assign imem_addr    = pc_q;
    assign id_instr     = instr_q;
    assign id_pc        = ipc_q;
    assign id_pc_plus4  = ipc4_q;
    assign id_valid     = valid_q;
    assign epc          = epc_q;
    assign irq_taken    = (state_q == ST_ENTER);
    assign id_ex_bubble = hazard | ex_branch_taken;

    // Load-use hazard: the load in EX writes a register the instruction in ID reads
    always_comb begin
        hazard = 1'b0;
        if (ex_mem_read && (ex_rt != 5'd0) && valid_q &&
            ((ex_rt == instr_q[25:21]) || (ex_rt == instr_q[20:16]))) begin
            hazard = 1'b1;
        end
    end

    // Entry waits for a quiet cycle so no pending redirect is dropped
    assign irq_enter = (state_q == ST_PEND) & irq & ~hazard & ~ex_branch_taken & ~id_jump;

    // Next-PC selection, highest priority first
    always_comb begin
        pc_d = pc_plus4;
        if (irq_enter) begin
            pc_d = ILLOP_PC;
        end else if (ex_branch_taken) begin
            pc_d = ex_branch_target;
        end else if (hazard) begin
            pc_d = pc_q;
        end else if (id_jump) begin
            pc_d = id_jump_target;
        end
    end

    // IF/ID register next state: flush on redirect, hold on stall, else capture the fetch
    always_comb begin
        instr_d = imem_rdata;
        ipc_d   = pc_q;
        ipc4_d  = pc_plus4;
        valid_d = 1'b1;
        if (irq_enter || ex_branch_taken || (id_jump && !hazard)) begin
            instr_d = NOP_INSTR;
            ipc_d   = 32'd0;
            ipc4_d  = 32'd0;
            valid_d = 1'b0;
        end else if (hazard) begin
            instr_d = instr_q;
            ipc_d   = ipc_q;
            ipc4_d  = ipc4_q;
            valid_d = valid_q;
        end
    end

    // Interrupt FSM; kernel mode (pc[31]) is never interrupted
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (irq && !pc_q[31]) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!irq) begin
                    state_d = ST_RUN;
                end else if (irq_enter) begin
                    state_d = ST_ENTER;
                end
            end
            ST_ENTER: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Return address is the fetch address discarded by the entry flush
    always_comb begin
        epc_d = epc_q;
        if (irq_enter) begin
            epc_d = pc_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'd0;
            ipc4_q  <= 32'd0;
            valid_q <= 1'b0;
            epc_q   <= 32'd0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            valid_q <= valid_d;
            epc_q   <= epc_d;
            state_q <= state_d;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles actually lost to load-use stalls, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !ex_branch_taken && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
